// File: rtl/divider_ratio_detector_pkg.sv
// Shared types and defaults for the divider ratio detector.
package divider_ratio_detector_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/divider_ratio_detector_edge_sync.sv
// Input synchronizer chain plus previous-sample flop; flags rising edges of the divided clock.
module divider_ratio_detector_edge_sync #(
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        chain[i] <= chain[i-1];
      end
      s_d <= chain[SYNC_STAGES-1];
    end
  end

  assign s      = chain[SYNC_STAGES-1];
  assign rise_c = s & ~s_d;

endmodule

// File: rtl/divider_ratio_detector.sv
// Measures period and high time of a divided clock in clk cycles, checks it against an
// expected ratio, tracks lock over repeated identical periods and flags a missing clock.
module divider_ratio_detector
  import divider_ratio_detector_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic [CNT_W-1:0] expected,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             mismatch,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT - 1);

  logic s;
  logic rise_c;

  state_t           state, state_nx;
  logic [CNT_W-1:0] period_cnt, period_cnt_nx;
  logic [CNT_W-1:0] high_cnt, high_cnt_nx;
  logic [CNT_W-1:0] prev_period, prev_period_nx;
  logic [CNT_W-1:0] match_cnt, match_cnt_nx;
  logic             first, first_nx;
  logic [CNT_W-1:0] period_out_nx, high_out_nx;
  logic             valid_nx, mismatch_nx, locked_nx, timeout_nx;

  divider_ratio_detector_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .s     (s),
    .rise_c(rise_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      period_cnt  <= '0;
      high_cnt    <= '0;
      prev_period <= '0;
      match_cnt   <= '0;
      first       <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      valid       <= 1'b0;
      mismatch    <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      period_cnt  <= period_cnt_nx;
      high_cnt    <= high_cnt_nx;
      prev_period <= prev_period_nx;
      match_cnt   <= match_cnt_nx;
      first       <= first_nx;
      period_out  <= period_out_nx;
      high_out    <= high_out_nx;
      valid       <= valid_nx;
      mismatch    <= mismatch_nx;
      locked      <= locked_nx;
      timeout     <= timeout_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    period_cnt_nx  = period_cnt;
    high_cnt_nx    = high_cnt;
    prev_period_nx = prev_period;
    match_cnt_nx   = match_cnt;
    first_nx       = first;
    period_out_nx  = period_out;
    high_out_nx    = high_out;
    valid_nx       = 1'b0;
    mismatch_nx    = 1'b0;
    locked_nx      = locked;
    timeout_nx     = timeout;

    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          period_cnt_nx = CNT_ONE;
          high_cnt_nx   = CNT_ONE;
          timeout_nx    = 1'b0;
          first_nx      = 1'b1;
          state_nx      = ST_MEASURE;
        end
      end

      ST_MEASURE, ST_LOCKED: begin
        if (rise_c) begin
          period_out_nx  = period_cnt;
          high_out_nx    = high_cnt;
          valid_nx       = 1'b1;
          mismatch_nx    = (period_cnt != expected);
          period_cnt_nx  = CNT_ONE;
          high_cnt_nx    = CNT_ONE;
          prev_period_nx = period_cnt;
          first_nx       = 1'b0;
          // The first period after IDLE has nothing to compare against.
          if (first || (period_cnt != prev_period)) begin
            match_cnt_nx = '0;
          end else if (match_cnt != LOCK_TGT) begin
            match_cnt_nx = match_cnt + CNT_ONE;
          end
          locked_nx = (match_cnt_nx == LOCK_TGT);
          state_nx  = locked_nx ? ST_LOCKED : ST_MEASURE;
        end else if (period_cnt == CNT_MAX) begin
          timeout_nx   = 1'b1;
          locked_nx    = 1'b0;
          match_cnt_nx = '0;
          state_nx     = ST_IDLE;
        end else begin
          period_cnt_nx = period_cnt + CNT_ONE;
          if (s && (high_cnt != CNT_MAX)) begin
            high_cnt_nx = high_cnt + CNT_ONE;
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_divider_ratio_detector.sv
// Randomized bench for divider_ratio_detector: two instances (1 and 2 sync stages)
// checked each cycle against a rise-timestamp model, plus hand-computed spot checks.
module tb_divider_ratio_detector;

  localparam int MAXC = 30000;
  localparam int TMO  = 255;
  localparam int LOCKN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       div_in = 1'b0;
  logic [7:0] expected = 8'd0;

  logic [7:0] period_o [2];
  logic [7:0] high_o   [2];
  logic       valid_o  [2];
  logic       mism_o   [2];
  logic       locked_o [2];
  logic       tmo_o    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider_ratio_detector #(.CNT_W(8), .LOCK_COUNT(LOCKN), .SYNC_STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .div_in(div_in), .expected(expected),
    .period_out(period_o[0]), .high_out(high_o[0]), .valid(valid_o[0]),
    .mismatch(mism_o[0]), .locked(locked_o[0]), .timeout(tmo_o[0])
  );

  divider_ratio_detector #(.CNT_W(8), .LOCK_COUNT(LOCKN), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .div_in(div_in), .expected(expected),
    .period_out(period_o[1]), .high_out(high_o[1]), .valid(valid_o[1]),
    .mismatch(mism_o[1]), .locked(locked_o[1]), .timeout(tmo_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: sampled input history, rise timestamps and prefix-free high counting.
  bit din_hist [MAXC];
  int cyc = 0;
  int last_rst = 0;
  int sync_of [2] = '{1, 2};

  bit m_active [2];
  bit m_first  [2];
  int m_start  [2];
  int m_prev   [2];
  int m_match  [2];
  int m_period [2];
  int m_high   [2];
  bit m_valid  [2];
  bit m_mism   [2];
  bit m_locked [2];
  bit m_tmo    [2];

  function automatic bit s_at(input int d, input int e);
    int k;
    k = e - sync_of[d];
    return (k > last_rst) ? din_hist[k] : 1'b0;
  endfunction

  task automatic model_reset(input int d);
    m_active[d] = 0; m_first[d] = 0; m_start[d] = 0; m_prev[d] = 0; m_match[d] = 0;
    m_period[d] = 0; m_high[d] = 0; m_valid[d] = 0; m_mism[d] = 0;
    m_locked[d] = 0; m_tmo[d] = 0;
  endtask

  task automatic model_step(input int d, input int e);
    bit r;
    int p;
    int h;
    m_valid[d] = 0;
    m_mism[d]  = 0;
    r = s_at(d, e) && !s_at(d, e - 1);
    if (!m_active[d]) begin
      if (r) begin
        m_active[d] = 1; m_start[d] = e; m_first[d] = 1; m_tmo[d] = 0;
      end
    end else if (r) begin
      p = e - m_start[d];
      h = 0;
      for (int k = m_start[d]; k < e; k++) h += int'(s_at(d, k));
      m_period[d] = p;
      m_high[d]   = h;
      m_valid[d]  = 1;
      m_mism[d]   = (p != int'(expected));
      if (m_first[d]) m_match[d] = 0;
      else if (p == m_prev[d]) m_match[d]++;
      else m_match[d] = 0;
      m_first[d]  = 0;
      m_prev[d]   = p;
      m_locked[d] = (m_match[d] >= LOCKN - 1);
      m_start[d]  = e;
    end else if (e - m_start[d] == TMO) begin
      m_tmo[d] = 1; m_locked[d] = 0; m_match[d] = 0; m_active[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d, want below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    din_hist[cyc] = div_in;
    if (!reset) begin
      last_rst = cyc;
      for (int d = 0; d < 2; d++) model_reset(d);
    end else begin
      for (int d = 0; d < 2; d++) model_step(d, cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_period", d), int'(period_o[d]), m_period[d]);
      chk($sformatf("dut%0d_high", d), int'(high_o[d]), m_high[d]);
      chk($sformatf("dut%0d_valid", d), int'(valid_o[d]), int'(m_valid[d]));
      chk($sformatf("dut%0d_mismatch", d), int'(mism_o[d]), int'(m_mism[d]));
      chk($sformatf("dut%0d_locked", d), int'(locked_o[d]), int'(m_locked[d]));
      chk($sformatf("dut%0d_timeout", d), int'(tmo_o[d]), int'(m_tmo[d]));
    end
  end

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      div_in = 1'b1;
      repeat (hi) @(negedge clk);
      div_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    int gap;
    bit seen;
    int idx;
    bit v0 [5];
    bit v1 [5];
    int hi, lo, n;

    for (int d = 0; d < 2; d++) model_reset(d);
    reset = 1'b0;
    expected = 8'd2;
    repeat (3) @(negedge clk);
    chk("reset_period", int'(period_o[0]), 0);
    chk("reset_valid", int'(valid_o[0]), 0);
    chk("reset_locked", int'(locked_o[0]), 0);
    chk("reset_timeout", int'(tmo_o[0]), 0);
    reset = 1'b1;

    // Divide-by-2, matching expectation.
    wave(1, 1, 8);
    chk("div2_period", int'(period_o[0]), 2);
    chk("div2_high", int'(high_o[0]), 1);
    chk("div2_locked", int'(locked_o[0]), 1);

    // Divide-by-3 against expected 2.
    wave(2, 1, 8);
    chk("div3_period", int'(period_o[0]), 3);
    chk("div3_high", int'(high_o[0]), 2);
    chk("div3_locked", int'(locked_o[0]), 1);

    // Lock at 4, step to 6, relock.
    expected = 8'd4;
    wave(2, 2, 8);
    chk("p4_locked", int'(locked_o[0]), 1);
    wave(3, 3, 2);
    chk("p6_period", int'(period_o[0]), 6);
    chk("p6_unlocked", int'(locked_o[0]), 0);
    wave(3, 3, 3);
    chk("p6_relocked", int'(locked_o[0]), 1);

    // Hold low until timeout; measure distance from the last valid.
    div_in = 1'b1;
    @(negedge clk);
    div_in = 1'b0;
    gap = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (valid_o[0]) gap = 0;
      else if (gap >= 0) gap++;
      if (tmo_o[0]) break;
    end
    chk("timeout_gap", gap, TMO);
    chk("timeout_unlocked", int'(locked_o[0]), 0);
    div_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) div_in = 1'b0;
      if (valid_o[0]) seen = 1;
    end
    chk("timeout_cleared", int'(tmo_o[0]), 0);
    chk("no_valid_on_restart", int'(seen), 0);

    // Rise lands exactly on the timeout threshold.
    wave(100, 155, 3);
    chk("p255_period", int'(period_o[0]), 255);
    chk("p255_high", int'(high_o[0]), 100);
    chk("p255_no_timeout", int'(tmo_o[0]), 0);

    // Reset pulse mid-measurement while locked.
    wave(2, 2, 8);
    div_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_period", int'(period_o[0]), 0);
    chk("midrst_high", int'(high_o[0]), 0);
    chk("midrst_locked", int'(locked_o[0]), 0);
    chk("midrst_valid", int'(valid_o[0]), 0);
    wave(2, 2, 4);

    // Divide-by-5: two-stage sync instance lags by one cycle.
    expected = 8'd5;
    wave(3, 2, 6);
    chk("sync2_period", int'(period_o[1]), 5);
    for (int i = 0; i < 5; i++) begin
      div_in = (i < 3);
      @(negedge clk);
      v0[i] = valid_o[0];
      v1[i] = valid_o[1];
    end
    idx = -1;
    for (int i = 0; i < 4; i++) if (v0[i] && idx < 0) idx = i;
    chk("sync1_valid_found", int'(idx >= 0), 1);
    if (idx >= 0) chk("sync2_valid_lag", int'(v1[idx+1]), 1);

    // Randomized segments with occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      hi = int'($urandom_range(1, 7));
      lo = int'($urandom_range(1, 7));
      n  = int'($urandom_range(1, 8));
      expected = ($urandom_range(0, 1) == 1) ? 8'(hi + lo) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      wave(hi, lo, n);
    end
    div_in = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
